// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEFAULT_N_USERS    = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting just after
// last_grant, wrapping at N_USERS, and reports the first one found.
module rr_pick #(
  parameter int N_USERS = 4,
  parameter int ID_W    = $clog2(N_USERS)
) (
  input  logic [N_USERS-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  // One extra bit so last_grant + offset cannot wrap before the modulo.
  logic [ID_W:0] cand;

  always_comb begin
    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= N_USERS; i++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_USERS)) cand = cand - (ID_W+1)'(N_USERS);
      if (!valid && req[cand[ID_W-1:0]]) begin
        valid  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates N_USERS single-word write requesters onto one FIFO write port,
// tagging each word with the winner id and reporting done/err per user.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_USERS    = DEFAULT_N_USERS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_W       = $clog2(N_USERS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_USERS-1:0]           user_req,
  input  logic [N_USERS*DATA_WIDTH-1:0] user_data,
  output logic [N_USERS-1:0]           user_grant,
  output logic [N_USERS-1:0]           user_done,
  output logic [N_USERS-1:0]           user_err,
  output logic                         fifo_wr_en,
  output logic [ID_W+DATA_WIDTH-1:0]   fifo_data_in,
  input  logic                         fifo_full,
  input  logic                         fifo_wr_ack,
  input  logic                         fifo_overflow,
  output logic                         busy
);

  state_t state_q, state_d;

  logic [ID_W-1:0]            last_grant_q;
  logic [ID_W-1:0]            win_id_q;
  logic [ID_W+DATA_WIDTH-1:0] fifo_data_q;
  logic [N_USERS-1:0]         grant_q, done_q, err_q;

  logic [ID_W-1:0]       pick_id;
  logic                  pick_valid;
  logic                  sel, finish_ok, finish_bad;
  logic [DATA_WIDTH-1:0] data_arr [N_USERS];

  always_comb begin
    for (int u = 0; u < N_USERS; u++) begin
      data_arr[u] = user_data[u*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_pick #(
    .N_USERS (N_USERS),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (user_req),
    .last_grant (last_grant_q),
    .winner     (pick_id),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    sel        = 1'b0;
    finish_ok  = 1'b0;
    finish_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid && !fifo_full) begin
          sel     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        // An overflow outranks a simultaneous ack: the word is treated as lost.
        if (fifo_wr_ack && !fifo_overflow) finish_ok  = 1'b1;
        else                               finish_bad = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(N_USERS - 1);
      win_id_q     <= '0;
      fifo_data_q  <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the defaults below make done/err 1-cycle pulses.
      done_q <= '0;
      err_q  <= '0;
      if (sel) begin
        win_id_q    <= pick_id;
        fifo_data_q <= {pick_id, data_arr[pick_id]};
        grant_q     <= N_USERS'(1) << pick_id;
      end
      if (finish_ok) begin
        done_q       <= grant_q;
        last_grant_q <= win_id_q;
      end
      if (finish_bad) err_q <= grant_q;
      if (finish_ok || finish_bad) grant_q <= '0;
    end
  end

  assign fifo_wr_en   = (state_q == WRITE);
  assign busy         = (state_q != IDLE);
  assign fifo_data_in = fifo_data_q;
  assign user_grant   = grant_q;
  assign user_done    = done_q;
  assign user_err     = err_q;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenario bench for fifo_wr_arbiter (4 users, 16-bit payload).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  user_req;
  logic [63:0] user_data;
  logic [3:0]  user_grant, user_done, user_err;
  logic        fifo_wr_en;
  logic [17:0] fifo_data_in;
  logic        fifo_full, fifo_wr_ack, fifo_overflow;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_USERS    (4),
    .DATA_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .user_req      (user_req),
    .user_data     (user_data),
    .user_grant    (user_grant),
    .user_done     (user_done),
    .user_err      (user_err),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow),
    .busy          (busy)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    user_req      = '0;
    user_data     = '0;
    fifo_full     = 1'b0;
    fifo_wr_ack   = 1'b1;
    fifo_overflow = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({fifo_wr_en, busy, user_grant, user_done, user_err, fifo_data_in} !== '0)
      $display("FAIL reset_outputs: got wr_en=%b busy=%b grant=%b done=%b err=%b data=%h, want all 0",
               fifo_wr_en, busy, user_grant, user_done, user_err, fifo_data_in);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    user_data[15:0] = 16'h1234;
    user_req        = 4'b0001;
    tick();
    total++;
    if ({fifo_wr_en, busy, user_grant} !== {1'b1, 1'b1, 4'b0001})
      $display("FAIL single_write: got wr_en=%b busy=%b grant=%b, want 1 1 0001", fifo_wr_en, busy, user_grant);
    else passed++;
    total++;
    if (fifo_data_in !== 18'h01234)
      $display("FAIL single_data: got %h, want 01234", fifo_data_in);
    else passed++;
    user_req = '0;
    tick();
    total++;
    if ({fifo_wr_en, busy, user_grant, user_done} !== {1'b0, 1'b1, 4'b0001, 4'b0000})
      $display("FAIL single_ack: got wr_en=%b busy=%b grant=%b done=%b, want 0 1 0001 0000",
               fifo_wr_en, busy, user_grant, user_done);
    else passed++;
    tick();
    total++;
    if ({user_done, user_err, user_grant, busy} !== {4'b0001, 4'b0000, 4'b0000, 1'b0})
      $display("FAIL single_done: got done=%b err=%b grant=%b busy=%b, want 0001 0000 0000 0",
               user_done, user_err, user_grant, busy);
    else passed++;
    tick();
    total++;
    if (user_done !== 4'b0000)
      $display("FAIL single_done_pulse: got done=%b, want 0000", user_done);
    else passed++;
  endtask

  task automatic test_round_robin();
    int done_cnt [4] = '{0, 0, 0, 0};
    do_reset();
    user_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int u = 0; u < 4; u++) done_cnt[u] += int'(user_done[u]);
      total++;
      if ({fifo_wr_en, user_grant} !== {1'b1, 4'(1 << k)})
        $display("FAIL rr_grant%0d: got wr_en=%b grant=%b, want 1 %b", k, fifo_wr_en, user_grant, 4'(1 << k));
      else passed++;
      tick();
      for (int u = 0; u < 4; u++) done_cnt[u] += int'(user_done[u]);
      tick();
      for (int u = 0; u < 4; u++) done_cnt[u] += int'(user_done[u]);
      total++;
      if (user_done !== 4'(1 << k))
        $display("FAIL rr_done%0d: got done=%b, want %b", k, user_done, 4'(1 << k));
      else passed++;
    end
    user_req = '0;
    tick();
    for (int u = 0; u < 4; u++) done_cnt[u] += int'(user_done[u]);
    for (int u = 0; u < 4; u++) begin
      total++;
      if (done_cnt[u] !== 1)
        $display("FAIL rr_done_count%0d: got %0d pulses, want 1", u, done_cnt[u]);
      else passed++;
    end
  endtask

  task automatic test_full();
    int bad = 0;
    do_reset();
    fifo_full = 1'b1;
    user_req  = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      if ({fifo_wr_en, busy, user_grant} !== '0) bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL full_blocks: got %0d cycles with activity, want 0", bad);
    else passed++;
    fifo_full = 1'b0;
    tick();
    total++;
    if ({fifo_wr_en, user_grant} !== {1'b1, 4'b0100})
      $display("FAIL full_release: got wr_en=%b grant=%b, want 1 0100", fifo_wr_en, user_grant);
    else passed++;
    user_req = '0;
    tick();
    tick();
    total++;
    if (user_done !== 4'b0100)
      $display("FAIL full_done: got done=%b, want 0100", user_done);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    user_req = 4'b0001;
    tick();
    user_req = 4'b1111;
    tick();
    tick();
    tick();
    total++;
    if (user_grant !== 4'b0010)
      $display("FAIL ovf_first_grant: got %b, want 0010", user_grant);
    else passed++;
    fifo_overflow = 1'b1;
    fifo_wr_ack   = 1'b0;
    tick();
    tick();
    total++;
    if ({user_err, user_done} !== {4'b0010, 4'b0000})
      $display("FAIL ovf_err: got err=%b done=%b, want 0010 0000", user_err, user_done);
    else passed++;
    fifo_overflow = 1'b0;
    fifo_wr_ack   = 1'b1;
    tick();
    total++;
    if ({fifo_wr_en, user_grant} !== {1'b1, 4'b0010})
      $display("FAIL ovf_retry_grant: got wr_en=%b grant=%b, want 1 0010", fifo_wr_en, user_grant);
    else passed++;
    tick();
    tick();
    total++;
    if ({user_done, user_err} !== {4'b0010, 4'b0000})
      $display("FAIL ovf_retry_done: got done=%b err=%b, want 0010 0000", user_done, user_err);
    else passed++;
    tick();
    total++;
    if (user_grant !== 4'b0100)
      $display("FAIL ovf_next_grant: got %b, want 0100", user_grant);
    else passed++;
    user_req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    user_req = 4'b0100;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_wr_en, busy, user_grant, user_done, user_err, fifo_data_in} !== '0)
      $display("FAIL midreset_outputs: got wr_en=%b busy=%b grant=%b done=%b err=%b data=%h, want all 0",
               fifo_wr_en, busy, user_grant, user_done, user_err, fifo_data_in);
    else passed++;
    user_req = 4'b1111;
    tick();
    total++;
    if ({user_done, user_err} !== '0)
      $display("FAIL midreset_no_pulse: got done=%b err=%b, want 0000 0000", user_done, user_err);
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if ({fifo_wr_en, user_grant} !== {1'b1, 4'b0001})
      $display("FAIL midreset_first_grant: got wr_en=%b grant=%b, want 1 0001", fifo_wr_en, user_grant);
    else passed++;
    user_req = '0;
    tick();
    tick();
  endtask

  task automatic test_drop_req();
    do_reset();
    user_req = 4'b0010;
    tick();
    user_req = 4'b0000;
    tick();
    tick();
    user_req = 4'b1000;
    tick();
    total++;
    if ({fifo_wr_en, user_grant} !== {1'b1, 4'b1000})
      $display("FAIL drop_grant3: got wr_en=%b grant=%b, want 1 1000", fifo_wr_en, user_grant);
    else passed++;
    user_req = 4'b0000;
    tick();
    total++;
    if (user_grant !== 4'b1000)
      $display("FAIL drop_grant_held: got %b, want 1000", user_grant);
    else passed++;
    user_req = 4'b1111;
    tick();
    total++;
    if (user_done !== 4'b1000)
      $display("FAIL drop_done3: got %b, want 1000", user_done);
    else passed++;
    tick();
    total++;
    if (user_grant !== 4'b0001)
      $display("FAIL drop_next_grant: got %b, want 0001", user_grant);
    else passed++;
    user_req = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_overflow();
    test_reset_mid_write();
    test_drop_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_USERS, default 4, meaning the number of write requesters.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the payload bits per request.
REQ-003 The block SHALL have parameter ID_W, default $clog2(N_USERS), meaning the user-tag width prepended to each FIFO word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port user_req, input, N_USERS bits: per-user write request, level.
REQ-007 The block SHALL have port user_data, input, N_USERS x DATA_WIDTH bits: per-user payload, valid while its req is high.
REQ-008 The block SHALL have port user_grant, output, N_USERS bits: one-hot grant, held from WRITE through ACK.
REQ-009 The block SHALL have port user_done, output, N_USERS bits: one-cycle pulse when the granted word is acknowledged.
REQ-010 The block SHALL have port user_err, output, N_USERS bits: one-cycle pulse when the granted write overflowed.
REQ-011 The block SHALL have port fifo_wr_en, output, 1 bit: FIFO write enable.
REQ-012 The block SHALL have port fifo_data_in, output, ID_W+DATA_WIDTH bits: {user id, payload}.
REQ-013 The block SHALL have ports fifo_full, fifo_wr_ack and fifo_overflow, inputs, 1 bit each: the FIFO status flags.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE and ACK.
REQ-016 In IDLE with any user_req high and fifo_full low, the block SHALL select a winner round-robin, starting at last_grant+1 (mod N_USERS) and wrapping.
REQ-017 On selection, the block SHALL latch {winner id, user_data[winner]} into fifo_data_in, set user_grant to one-hot of the winner, and go to WRITE.
REQ-018 In IDLE with fifo_full high, the block SHALL grant nothing and stay in IDLE; almostfull has no effect.
REQ-019 In WRITE, fifo_wr_en SHALL be high for exactly one cycle, and the FSM SHALL go to ACK unconditionally.
REQ-020 ACK SHALL last exactly one cycle.
REQ-021 In ACK, if fifo_wr_ack is high, the block SHALL pulse user_done[winner] and set last_grant to the winner.
REQ-022 In ACK, if fifo_overflow is high or fifo_wr_ack is low, the block SHALL pulse user_err[winner] and leave last_grant unchanged, so the same user wins the next retry.
REQ-023 The block SHALL return from ACK to IDLE; done and err SHALL be registered pulses that appear the cycle after ACK.
REQ-024 Throughput SHALL be at most one word per 3 cycles; latency from req to fifo_wr_en SHALL be 1 cycle when the block is idle and not full.
REQ-025 If a requester drops user_req after grant, the write SHALL still complete and done/err SHALL still pulse.
REQ-026 fifo_wr_en SHALL never be asserted while state is not WRITE.
REQ-027 user_grant, user_done and user_err SHALL each always be one-hot or zero.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE; fifo_wr_en=0; fifo_data_in=0; user_grant=0; user_done=0; user_err=0; busy=0; last_grant=N_USERS-1, so user 0 wins first.
REQ-029 Reset asserted mid-WRITE or mid-ACK SHALL abort the transfer with no done/err pulse.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE, WRITE, ACK) and the default N_USERS/DATA_WIDTH constants.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: req vector, last_grant; outputs: winner index, valid).

Verification
REQ-032 Scenario: after reset, user_req=4'b0001, data 0x1234, not full -> fifo_wr_en high in cycle 2, fifo_data_in=0x01234 (id 0), user_done[0] pulse 2 cycles later.
REQ-033 Scenario: user_req=4'b1111 held for 12 cycles -> grants in order 0,1,2,3, one every 3 cycles, each done exactly once.
REQ-034 Scenario: fifo_full=1 with req=4'b0100 -> no fifo_wr_en and busy=0 until full drops, then user 2 is granted the next cycle.
REQ-035 Scenario: force fifo_overflow=1, fifo_wr_ack=0 in ACK for user 1 -> user_err[1] pulse, and the next grant is user 1 again even with req=4'b1111.
REQ-036 Scenario: rst_n low during WRITE -> all outputs 0 immediately; after release user 0 wins first.
REQ-037 Scenario: user 3 drops req in WRITE -> write still issued and user_done[3] pulses; next grant goes to user 0.
